stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: two debounced active-low buttons drive an IDLE/RUN/PAUSE FSM
// that gates a prescaler emitting one active-low count pulse every DIV cycles.
module stopwatch_ctrl #(
   parameter int unsigned DIV       = 500000,
   parameter int unsigned DB_CYCLES = 200000
) (
   input  logic       CP,
   input  logic       CLR,
   input  logic       invSTART,
   input  logic       invCLEAR,
   output logic       invCNT,
   output logic       CNT_CLR,
   output logic       RUNNING,
   output logic [1:0] STATE
);

   localparam int unsigned PSC_W = $clog2(DIV);
   localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);
   localparam int unsigned NBTN  = 2;
   localparam int unsigned BTN_START = 0;
   localparam int unsigned BTN_CLEAR = 1;
   localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10
   } state_e;

   logic [NBTN-1:0] sync1_q, sync1_d;
   logic [NBTN-1:0] sync2_q, sync2_d;
   logic [NBTN-1:0] lvl_q,   lvl_d;
   logic [NBTN-1:0] ev_q,    ev_d;
   logic [DB_W-1:0] cnt_q [NBTN];
   logic [DB_W-1:0] cnt_d [NBTN];

   state_e           state_q, state_d;
   logic [PSC_W-1:0] psc_q,   psc_d;
   logic             invcnt_q, invcnt_d;
   logic             cnt_clr_q, cnt_clr_d;

   logic start_ev;
   logic clear_ev;

   // Synchronize, debounce and edge-detect both buttons; a level is accepted
   // only after DB_CYCLES consecutive differing samples.
   always_comb begin
      sync1_d = {invCLEAR, invSTART};
      sync2_d = sync1_q;
      lvl_d   = lvl_q;
      ev_d    = '0;
      for (int i = 0; i < int'(NBTN); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != lvl_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               lvl_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
         end
         ev_d[i] = lvl_q[i] & ~lvl_d[i];
      end
   end

   assign start_ev = ev_q[BTN_START];
   assign clear_ev = ev_q[BTN_CLEAR];

   // Next state, prescaler and output pulses; tick decision uses the pre-edge state.
   always_comb begin
      state_d   = state_q;
      psc_d     = psc_q;
      cnt_clr_d = 1'b0;
      invcnt_d  = ~((state_q == S_RUN) && (psc_q == PSC_MAX));
      case (state_q)
         S_IDLE: begin
            psc_d = '0;
            if (clear_ev) begin
               cnt_clr_d = 1'b1;
            end else if (start_ev) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            psc_d = (psc_q == PSC_MAX) ? '0 : psc_q + PSC_W'(1);
            if (start_ev) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (clear_ev) begin
               state_d   = S_IDLE;
               psc_d     = '0;
               cnt_clr_d = 1'b1;
            end else if (start_ev) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
            psc_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CP) begin
      if (CLR) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         lvl_q     <= '1;
         ev_q      <= '0;
         for (int i = 0; i < int'(NBTN); i++) begin
            cnt_q[i] <= '0;
         end
         state_q   <= S_IDLE;
         psc_q     <= '0;
         invcnt_q  <= 1'b1;
         cnt_clr_q <= 1'b1;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         lvl_q     <= lvl_d;
         ev_q      <= ev_d;
         for (int i = 0; i < int'(NBTN); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         state_q   <= state_d;
         psc_q     <= psc_d;
         invcnt_q  <= invcnt_d;
         cnt_clr_q <= cnt_clr_d;
      end
   end

   assign invCNT  = invcnt_q;
   assign CNT_CLR = cnt_clr_q;
   assign STATE   = state_q;
   assign RUNNING = (state_q == S_RUN);

endmodule
